// File: rtl/prio_arb_enc.sv
// -----------------------------------------------------------------------------
// prio_arb_enc
//   Registered N-input arbiter / priority encoder with a sticky grant.
//   It replaces the older 4-input combinational priority encoder. A grant
//   stays in place until the consumer acknowledges it. An acknowledge can
//   re-arbitrate on the same edge, so one grant per cycle is possible.
//
//   mode 0 : fixed priority, highest requesting index wins (legacy ordering)
//   mode 1 : round-robin; the search starts at ptr and goes downwards with
//            wrap, and ptr moves to one below each acknowledged winner
//
// Ports
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   en      arbitration enable; when low, no new grant is started
//   mode    0 = fixed priority, 1 = round-robin (sampled at arbitration edges)
//   req     request vector, bit i = requester i
//   ack     consumer accepts the current grant (ignored while valid = 0)
//   valid   a grant is being presented
//   idx     binary index of the granted requester (held after the grant ends)
//   onehot  one-hot grant, 1 << idx while valid, zero otherwise
//   busy    FSM is in GRANT (same as valid)
//
// State table
//   IDLE   | no grant outstanding, waiting for en && req != 0
//   GRANT  | grant presented on idx/onehot, held until ack
// -----------------------------------------------------------------------------
module prio_arb_enc #(
  parameter  int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         mode,
  input  logic [N-1:0] req,
  input  logic         ack,
  output logic         valid,
  output logic [W-1:0] idx,
  output logic [N-1:0] onehot,
  output logic         busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [W-1:0] TOP = W'(N - 1);

  state_t         state, state_n;
  logic [W-1:0]   idx_n;
  logic [N-1:0]   onehot_n;
  logic [W-1:0]   ptr, ptr_n;
  logic [N-1:0]   masked;

  // The search order p, p-1, ..., 0, N-1, ..., p+1 is handled by rotating the
  // request vector. Bit j of the rotated window is index (p+1+j) mod N, so
  // requester p ends up on the top bit. The highest set bit of the window is
  // therefore the winner. The doubled vector is used so that the rotation
  // wraps at N and not at 2^W.
  function automatic logic [W-1:0] win(input logic [N-1:0] r,
                                       input logic [W-1:0] p);
    logic [N-1:0] window;
    int           sum;
    window = N'({r, r} >> (int'(p) + 1));
    sum    = 0;
    for (int j = 0; j < N; j++) begin
      if (window[j]) sum = int'(p) + 1 + j;
    end
    if (sum >= N) sum = sum - N;
    return W'(sum);
  endfunction

  function automatic logic [N-1:0] to_onehot(input logic [W-1:0] i);
    return {{(N-1){1'b0}}, 1'b1} << i;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      onehot <= '0;
      ptr    <= TOP;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      onehot <= onehot_n;
      ptr    <= ptr_n;
    end
  end

  always_comb begin
    state_n  = state;
    idx_n    = idx;
    onehot_n = onehot;
    ptr_n    = ptr;
    // While a grant is held, onehot is 1<<k. This takes the granted bit out
    // for the back-to-back re-arbitration.
    masked   = req & ~onehot;

    unique case (state)
      IDLE: begin
        if (en && (|req)) begin
          idx_n    = win(req, mode ? ptr : TOP);
          onehot_n = to_onehot(idx_n);
          state_n  = GRANT;
        end
      end

      GRANT: begin
        if (ack) begin
          if (mode) ptr_n = (idx == '0) ? TOP : (idx - W'(1));
          if (en && (|masked)) begin
            idx_n    = win(masked, mode ? ptr_n : TOP);
            onehot_n = to_onehot(idx_n);
          end else begin
            onehot_n = '0;
            state_n  = IDLE;
          end
        end
      end

      default: begin
        state_n  = IDLE;
        onehot_n = '0;
      end
    endcase
  end

  assign valid = (state == GRANT);
  assign busy  = (state == GRANT);

endmodule

// File: tb/tb_prio_arb_enc.sv
// -----------------------------------------------------------------------------
// tb_prio_arb_enc
//   Self-checking bench for prio_arb_enc. It runs an N=4 instance and an N=5
//   instance. The checks are a legacy-encoder vector table, hand-written
//   sequences for the multi-cycle corner cases, and randomized traffic. The
//   random traffic is compared against a cycle model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_prio_arb_enc;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       en, mode, ack;
  logic [3:0] req;
  logic       valid, busy;
  logic [1:0] idx;
  logic [3:0] onehot;

  logic       en5, mode5, ack5;
  logic [4:0] req5;
  logic       valid5, busy5;
  logic [2:0] idx5;
  logic [4:0] onehot5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prio_arb_enc #(.N(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .req(req), .ack(ack),
    .valid(valid), .idx(idx), .onehot(onehot), .busy(busy)
  );

  prio_arb_enc #(.N(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .en(en5), .mode(mode5), .req(req5), .ack(ack5),
    .valid(valid5), .idx(idx5), .onehot(onehot5), .busy(busy5)
  );

  // ---------------------------------------------------------------- helpers
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------- model
  typedef struct {
    bit v;
    int idx;
    int ptr;
  } mstate_t;

  // Walk the priority order p, p-1, ..., wrapping modulo n.
  function automatic int mwin(input int n, input logic [31:0] r, input int p);
    for (int j = 0; j < n; j++) begin
      int c;
      c = (p - j + n) % n;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic mstate_t mreset(input int n);
    mstate_t s;
    s.v = 1'b0; s.idx = 0; s.ptr = n - 1;
    return s;
  endfunction

  function automatic mstate_t mnext(input mstate_t s, input int n, input bit e,
                                    input bit md, input logic [31:0] r,
                                    input bit a);
    mstate_t     t;
    logic [31:0] m;
    int          k;
    t = s;
    if (!s.v) begin
      if (e && r != 0) begin
        t.idx = mwin(n, r, md ? s.ptr : n - 1);
        t.v   = 1'b1;
      end
    end else if (a) begin
      k = s.idx;
      if (md) t.ptr = (k + n - 1) % n;
      m = r & ~(32'd1 << k);
      if (e && m != 0) t.idx = mwin(n, m, md ? t.ptr : n - 1);
      else             t.v   = 1'b0;
    end
    return t;
  endfunction

  task automatic cmp4(input string tag, input mstate_t s);
    chk({tag, "_valid"}, int'(valid), int'(s.v));
    chk({tag, "_busy"},  int'(busy),  int'(s.v));
    chk({tag, "_onehot"}, int'(onehot), s.v ? (1 << s.idx) : 0);
    if (s.v) chk({tag, "_idx"}, int'(idx), s.idx);
  endtask

  task automatic cmp5(input string tag, input mstate_t s);
    chk({tag, "_valid"}, int'(valid5), int'(s.v));
    chk({tag, "_busy"},  int'(busy5),  int'(s.v));
    chk({tag, "_onehot"}, int'(onehot5), s.v ? (1 << s.idx) : 0);
    if (s.v) chk({tag, "_idx"}, int'(idx5), s.idx);
    chk({tag, "_idx_range"}, int'(idx5 <= 3'd4), 1);
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic [3:0] req;
    bit         v;
    int         idx;
    logic [3:0] oh;
  } vec_t;

  vec_t tbl[16];

  int rr_full[6] = '{3, 2, 1, 0, 3, 2};
  int rr_alt[4]  = '{3, 1, 3, 1};
  int n5_sparse[4] = '{4, 0, 4, 0};
  int n5_full[6]   = '{4, 3, 2, 1, 0, 4};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    mstate_t s4, s5;

    tbl[0]  = '{4'h0, 1'b0, 0, 4'h0};
    tbl[1]  = '{4'h1, 1'b1, 0, 4'h1};
    tbl[2]  = '{4'h2, 1'b1, 1, 4'h2};
    tbl[3]  = '{4'h3, 1'b1, 1, 4'h2};
    tbl[4]  = '{4'h4, 1'b1, 2, 4'h4};
    tbl[5]  = '{4'h5, 1'b1, 2, 4'h4};
    tbl[6]  = '{4'h6, 1'b1, 2, 4'h4};
    tbl[7]  = '{4'h7, 1'b1, 2, 4'h4};
    tbl[8]  = '{4'h8, 1'b1, 3, 4'h8};
    tbl[9]  = '{4'h9, 1'b1, 3, 4'h8};
    tbl[10] = '{4'hA, 1'b1, 3, 4'h8};
    tbl[11] = '{4'hB, 1'b1, 3, 4'h8};
    tbl[12] = '{4'hC, 1'b1, 3, 4'h8};
    tbl[13] = '{4'hD, 1'b1, 3, 4'h8};
    tbl[14] = '{4'hE, 1'b1, 3, 4'h8};
    tbl[15] = '{4'hF, 1'b1, 3, 4'h8};

    rst_n = 1'b0;
    en = 1'b0; mode = 1'b0; ack = 1'b0; req = '0;
    en5 = 1'b0; mode5 = 1'b0; ack5 = 1'b0; req5 = '0;

    // ---- reset state
    #12;
    chk("rst_valid",  int'(valid),  0);
    chk("rst_onehot", int'(onehot), 0);
    chk("rst_idx",    int'(idx),    0);
    chk("rst_busy",   int'(busy),   0);
    chk("rst5_valid", int'(valid5), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- legacy encoder table, fixed mode
    for (int i = 0; i < 16; i++) begin
      req = tbl[i].req; en = 1'b1; mode = 1'b0; ack = 1'b0;
      step();
      chk($sformatf("tbl%0d_valid", i), int'(valid), int'(tbl[i].v));
      if (tbl[i].v) chk($sformatf("tbl%0d_idx", i), int'(idx), tbl[i].idx);
      chk($sformatf("tbl%0d_onehot", i), int'(onehot), int'(tbl[i].oh));
      req = '0; ack = 1'b1;
      step();
      chk($sformatf("tbl%0d_release", i), int'(valid), 0);
      ack = 1'b0;
    end

    // ---- sticky grant
    do_reset();
    mode = 1'b0; en = 1'b1; ack = 1'b0; req = 4'b0010;
    step();
    chk("sticky_idx", int'(idx), 1);
    req = 4'b0000;
    for (int c = 0; c < 5; c++) begin
      mode = c[0];
      en   = (c != 2);
      if (c == 3) req = 4'b1100;
      step();
      chk($sformatf("sticky%0d_valid", c), int'(valid), 1);
      chk($sformatf("sticky%0d_idx", c), int'(idx), 1);
      chk($sformatf("sticky%0d_onehot", c), int'(onehot), 2);
    end
    mode = 1'b0; en = 1'b1; req = 4'b0000; ack = 1'b1;
    step();
    chk("sticky_end_valid",  int'(valid),  0);
    chk("sticky_end_onehot", int'(onehot), 0);
    ack = 1'b0;

    // ---- round-robin rotation, all requesting
    do_reset();
    mode = 1'b1; en = 1'b1; req = 4'hF; ack = 1'b1;
    foreach (rr_full[i]) begin
      step();
      chk($sformatf("rr_full%0d_valid", i), int'(valid), 1);
      chk($sformatf("rr_full%0d_idx", i), int'(idx), rr_full[i]);
    end

    // ---- round-robin rotation, req = 1010
    do_reset();
    req = 4'b1010;
    foreach (rr_alt[i]) begin
      step();
      chk($sformatf("rr_alt%0d_valid", i), int'(valid), 1);
      chk($sformatf("rr_alt%0d_idx", i), int'(idx), rr_alt[i]);
    end

    // ---- back-to-back masking, fixed mode
    do_reset();
    mode = 1'b0; req = 4'b1000; ack = 1'b1;
    step();
    chk("mask_g1_valid", int'(valid), 1);
    chk("mask_g1_idx",   int'(idx),   3);
    step();
    chk("mask_drop_valid", int'(valid), 0);
    step();
    chk("mask_g2_valid", int'(valid), 1);
    chk("mask_g2_idx",   int'(idx),   3);

    // ---- ack while idle is ignored (ptr must stay at N-1)
    do_reset();
    mode = 1'b1; en = 1'b1; req = '0; ack = 1'b1;
    step(); step();
    chk("idle_ack_valid", int'(valid), 0);
    ack = 1'b0; req = 4'hF;
    step();
    chk("idle_ack_idx", int'(idx), 3);

    // ---- enable gating
    do_reset();
    mode = 1'b0; en = 1'b0; req = 4'hF; ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("en_off%0d_valid", c), int'(valid), 0);
    end
    en = 1'b1; req = 4'b0100;
    step();
    chk("en_grant_idx", int'(idx), 2);
    en = 1'b0; ack = 1'b1; req = 4'hF;
    step();
    chk("en_drop_valid",  int'(valid),  0);
    chk("en_drop_onehot", int'(onehot), 0);
    ack = 1'b0;

    // ---- async reset mid-grant, ptr returns to N-1
    do_reset();
    mode = 1'b1; en = 1'b1; req = 4'hF; ack = 1'b1;
    step(); step();
    chk("arst_pre_idx", int'(idx), 2);
    ack = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid",  int'(valid),  0);
    chk("arst_onehot", int'(onehot), 0);
    chk("arst_busy",   int'(busy),   0);
    chk("arst_idx",    int'(idx),    0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("arst_ptr_idx", int'(idx), 3);

    // ---- N=5 round-robin
    do_reset();
    mode5 = 1'b1; en5 = 1'b1; ack5 = 1'b1; req5 = 5'b10001;
    foreach (n5_sparse[i]) begin
      step();
      chk($sformatf("n5_sparse%0d_valid", i), int'(valid5), 1);
      chk($sformatf("n5_sparse%0d_idx", i), int'(idx5), n5_sparse[i]);
    end
    do_reset();
    req5 = 5'b11111;
    foreach (n5_full[i]) begin
      step();
      chk($sformatf("n5_full%0d_valid", i), int'(valid5), 1);
      chk($sformatf("n5_full%0d_idx", i), int'(idx5), n5_full[i]);
    end

    // ---- randomized traffic against the model
    do_reset();
    s4 = mreset(4);
    s5 = mreset(5);
    for (int c = 0; c < 600; c++) begin
      en    = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      req   = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      ack   = $urandom_range(0, 1);
      en5   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) mode5 = ~mode5;
      req5  = ($urandom_range(0, 3) == 0) ? 5'h0 : 5'($urandom);
      ack5  = ($urandom_range(0, 2) != 0);
      s4 = mnext(s4, 4, en,  mode,  32'(req),  ack);
      s5 = mnext(s5, 5, en5, mode5, 32'(req5), ack5);
      step();
      cmp4($sformatf("rnd4_%0d", c), s4);
      cmp5($sformatf("rnd5_%0d", c), s5);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
